memory_access_controller: RTL
=============================

Name: memory_access_controller

Overview:
Sequences single CPU memory transactions between the control unit and external memory over a req/ack handshake. It sits directly upstream of the memory buffer register. Read data is captured and held on rdata_out, which drives the MBR data input. Each transaction reports completion or timeout back to the control unit.

Parameters:
ADDR_WIDTH, 12, width of the memory address (MAR width)
DATA_WIDTH, 16, width of the data word (matches the MBR)
TIMEOUT, 15, max cycles in ACCESS waiting for mem_ack before abort (1..255)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
cpu_rd  input  1  read request, sampled only in IDLE
cpu_wr  input  1  write request, sampled only in IDLE
cpu_addr  input  ADDR_WIDTH  transaction address (from MAR)
cpu_wdata  input  DATA_WIDTH  write data
cpu_busy  output  1  high while state != IDLE
cpu_done  output  1  one-cycle completion pulse
cpu_err  output  1  one-cycle timeout pulse, coincident with cpu_done
rdata_out  output  DATA_WIDTH  last successfully read word, to MBR data_input
mem_req  output  1  memory request, held until ack or timeout
mem_we  output  1  1 = write, 0 = read; valid while mem_req
mem_addr  output  ADDR_WIDTH  latched address
mem_wdata  output  DATA_WIDTH  latched write data
mem_ack  input  1  memory acknowledge; read data valid on the same edge
mem_rdata  input  DATA_WIDTH  memory read data

Behaviour:
- Reset (async, immediate):
  - State IDLE; wait counter 0.
  - All outputs 0, including rdata_out, mem_req, mem_we, mem_addr and mem_wdata.
- States: IDLE, ACCESS, DONE. All outputs are registered.
- IDLE:
  - On cpu_rd or cpu_wr at a clock edge: latch cpu_addr into mem_addr and cpu_wdata into mem_wdata.
  - Set mem_we = cpu_wr, mem_req = 1, counter = 0, then go to ACCESS.
  - If cpu_rd and cpu_wr are both high, the write wins and the read is dropped.
  - With no request, stay in IDLE.
- ACCESS:
  - mem_req stays 1; address, data and mem_we stay stable.
  - On an edge with mem_ack = 1: clear mem_req. For a read, load rdata_out <= mem_rdata. Go to DONE with cpu_done = 1.
  - Otherwise the counter increments. If the counter reaches TIMEOUT-1 without an ack: clear mem_req, set cpu_done = 1 and cpu_err = 1, go to DONE. rdata_out is unchanged.
  - If ack and timeout land on the same edge, the ack wins and there is no error.
- DONE:
  - cpu_done (and cpu_err if timed out) is high for exactly this one cycle.
  - Clear both flags and return to IDLE unconditionally.
- cpu_busy is high in ACCESS and DONE.
- Requests while busy are ignored and not queued. The control unit re-issues them after cpu_done.
- Minimum latency: request sampled at edge 0, mem_req high after edge 0, ack at edge 1, cpu_done high after edge 1. The next request can be accepted at edge 3.
- mem_ack in IDLE or DONE is ignored; rdata_out does not change.
- rdata_out changes only on a read-ack edge. Writes and timeouts leave it unchanged.
- mem_addr, mem_wdata and mem_we keep their last values in IDLE; only mem_req qualifies them.
- Reset mid-ACCESS: mem_req drops asynchronously, the transaction is abandoned, and no done/err pulse is produced.

Test Plan:
- Read, zero wait: cpu_rd=1, addr=0x0A5; mem_ack=1 on the first mem_req edge with mem_rdata=0xBEEF -> mem_req high 1 cycle, mem_we=0, rdata_out=0xBEEF, cpu_done 1-cycle pulse, cpu_err=0.
- Read with 3 wait cycles: ack on the 4th ACCESS edge with rdata=0x1234 -> mem_req high 4 cycles, cpu_busy high 5 cycles, rdata_out=0x1234 after ack.
- Write: cpu_wr=1, addr=0xFFF, wdata=0xA55A, ack after 2 cycles -> mem_we=1, mem_addr=0xFFF, mem_wdata=0xA55A, rdata_out keeps its prior 0x1234.
- Timeout: read with no ack, TIMEOUT=15 -> mem_req drops after 15 cycles, cpu_done and cpu_err pulse together, rdata_out unchanged. Also check ack on the 15th edge -> no error.
- Conflicts: cpu_rd and cpu_wr both set -> write performed. A new cpu_rd while busy -> ignored, no second mem_req.
- Reset at the 2nd ACCESS cycle -> mem_req=0 immediately, all outputs 0, no cpu_done. The next read after reset completes normally.

Source files
------------

// File: rtl/memory_access_controller.sv
// memory_access_controller: single-transaction req/ack memory sequencer between control unit and memory, with timeout and registered outputs
module memory_access_controller #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_rd,
    input  logic                  cpu_wr,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_busy,
    output logic                  cpu_done,
    output logic                  cpu_err,
    output logic [DATA_WIDTH-1:0] rdata_out,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
    state_t state, state_n;
    logic [7:0] cnt, cnt_n;
    logic req_n, we_n, done_n, err_n;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic [DATA_WIDTH-1:0] wdata_n, rdata_n;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            cpu_busy  <= 1'b0;
            cpu_done  <= 1'b0;
            cpu_err   <= 1'b0;
            rdata_out <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            cpu_busy  <= state_n != IDLE;
            cpu_done  <= done_n;
            cpu_err   <= err_n;
            rdata_out <= rdata_n;
            mem_req   <= req_n;
            mem_we    <= we_n;
            mem_addr  <= addr_n;
            mem_wdata <= wdata_n;
        end
    end
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        req_n   = mem_req;
        we_n    = mem_we;
        addr_n  = mem_addr;
        wdata_n = mem_wdata;
        rdata_n = rdata_out;
        done_n  = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: if (cpu_rd || cpu_wr) begin
                state_n = ACCESS;
                cnt_n   = '0;
                req_n   = 1'b1;
                we_n    = cpu_wr;
                addr_n  = cpu_addr;
                wdata_n = cpu_wdata;
            end
            ACCESS: if (mem_ack) begin
                state_n = DONE;
                req_n   = 1'b0;
                done_n  = 1'b1;
                rdata_n = mem_we ? rdata_out : mem_rdata;
            end else if (cnt == LAST) begin
                state_n = DONE;
                req_n   = 1'b0;
                done_n  = 1'b1;
                err_n   = 1'b1;
            end else begin
                cnt_n = cnt + 8'd1;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule
